// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the register-file write port between writeback and a buffered long-latency unit.
module rf_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [37:0]   ws_to_rf_bus,
  output logic          ws_stall,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [4:0]    lu_dest,
  input  logic [31:0]   lu_wdata,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  input  logic [4:0]    ds_raddr1,
  input  logic [4:0]    ds_raddr2,
  output logic          ds_pend_hit,
  output logic [CW-1:0] fifo_count
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]            dest_q [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt;
  logic                  ws_we, empty, starve, lu_grant, enq;
  assign ws_we    = ws_to_rf_bus[37];
  assign empty    = count == '0;
  assign starve   = starve_cnt >= SW'(STARVE_LIMIT);
  assign lu_grant = !empty && (!ws_we || starve);
  assign lu_ready = resetn && (count < CW'(FIFO_DEPTH));
  // r0 results complete the handshake but never occupy a slot
  assign enq      = lu_valid && lu_ready && lu_dest != '0;
  assign rf_we    = resetn && (lu_grant || ws_we);
  assign rf_waddr = lu_grant ? dest_q[rd_ptr] : ws_to_rf_bus[36:32];
  assign rf_wdata = lu_grant ? data_q[rd_ptr] : ws_to_rf_bus[31:0];
  assign ws_stall = resetn && lu_grant && ws_we;
  assign fifo_count = count;
  always_comb begin
    ds_pend_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      ds_pend_hit |= vld[i] && ((dest_q[i] == ds_raddr1 && ds_raddr1 != '0) ||
                                (dest_q[i] == ds_raddr2 && ds_raddr2 != '0));
    ds_pend_hit &= resetn;
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      dest_q[wr_ptr] <= lu_dest;
      data_q[wr_ptr] <= lu_wdata;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      vld        <= '0;
      starve_cnt <= '0;
    end else begin
      if (enq) begin
        wr_ptr      <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
        vld[wr_ptr] <= 1'b1;
      end
      if (lu_grant) begin
        rd_ptr      <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
        vld[rd_ptr] <= 1'b0;
      end
      count      <= count + CW'(enq) - CW'(lu_grant);
      starve_cnt <= (empty || lu_grant) ? '0 : starve ? starve_cnt : starve_cnt + SW'(1);
    end
  end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: table-driven cycle vectors plus an asynchronous mid-operation reset sequence.
module tb_rf_wport_arbiter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [37:0] ws_to_rf_bus = '0;
  logic        ws_stall, lu_ready, rf_we, ds_pend_hit;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_dest = '0, ds_raddr1 = '0, ds_raddr2 = '0, rf_waddr;
  logic [31:0] lu_wdata = '0, rf_wdata;
  logic [1:0]  fifo_count;
  int errors = 0, checks = 0;

  typedef struct packed {
    logic        ws_we;
    logic [4:0]  ws_wa;
    logic [31:0] ws_wd;
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] lwd;
    logic [4:0]  r1, r2;
    logic [42:0] exp;
  } vec_t;
  vec_t vq[$];

  rf_wport_arbiter dut (
    .clk(clk), .resetn(resetn), .ws_to_rf_bus(ws_to_rf_bus), .ws_stall(ws_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dest(lu_dest), .lu_wdata(lu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2), .ds_pend_hit(ds_pend_hit),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic v(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                   input logic lv, input logic [4:0] ld, input logic [31:0] lwd,
                   input logic [4:0] r1, input logic [4:0] r2,
                   input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
                   input logic e_stall, input logic e_ready, input logic e_pend,
                   input logic [1:0] e_cnt);
    vq.push_back('{we, wa, wd, lv, ld, lwd, r1, r2,
                   {e_we, e_wa, e_wd, e_stall, e_ready, e_pend, e_cnt}});
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] ld, input logic [31:0] lwd);
    ws_to_rf_bus = {we, wa, wd};
    lu_valid = lv;
    lu_dest = ld;
    lu_wdata = lwd;
  endtask

  initial begin
    // idle WS: LU result written the cycle after acceptance
    v(0,0,0,       1,5,32'h1234, 0,0,  0,0,0,             0,1,0,0);
    v(0,0,0,       0,0,0,        0,0,  1,5,32'h1234,      0,1,0,1);
    v(0,0,0,       0,0,0,        0,0,  0,0,0,             0,1,0,0);
    // r0 result is accepted and dropped
    v(0,0,0,       1,0,32'hdead, 0,0,  0,0,0,             0,1,0,0);
    v(0,0,0,       0,0,0,        0,0,  0,0,0,             0,1,0,0);
    // pending hit: in-flight dest not compared, then registered entry 9
    v(0,0,0,       1,9,32'h99,   9,0,  0,0,0,             0,1,0,0);
    v(1,3,32'hb,   0,0,0,        9,0,  1,3,32'hb,         0,1,1,1);
    v(1,3,32'hb,   0,0,0,        0,8,  1,3,32'hb,         0,1,0,1);
    v(0,0,0,       0,0,0,        9,0,  1,9,32'h99,        0,1,1,1);
    v(0,0,0,       0,0,0,        9,0,  0,0,0,             0,1,0,0);
    // WS priority until starve limit, then one stalled LU grant
    v(1,3,32'hb,   1,7,32'ha,    0,0,  1,3,32'hb,         0,1,0,0);
    for (int i = 0; i < 4; i++)
      v(1,3,32'hb, 0,0,0,        0,0,  1,3,32'hb,         0,1,0,1);
    v(1,3,32'hb,   0,0,0,        0,0,  1,7,32'ha,         1,1,0,1);
    v(1,3,32'hb,   0,0,0,        0,0,  1,3,32'hb,         0,1,0,0);
    // full FIFO: third push refused, even on the dequeue cycle; order kept
    v(1,4,32'hc,   1,1,32'h11,   0,0,  1,4,32'hc,         0,1,0,0);
    v(1,4,32'hc,   1,2,32'h22,   0,1,  1,4,32'hc,         0,1,1,1);
    v(1,4,32'hc,   1,6,32'h66,   0,0,  1,4,32'hc,         0,0,0,2);
    v(1,4,32'hc,   0,0,0,        0,0,  1,4,32'hc,         0,0,0,2);
    v(1,4,32'hc,   0,0,0,        0,0,  1,4,32'hc,         0,0,0,2);
    v(1,4,32'hc,   1,6,32'h66,   0,0,  1,1,32'h11,        1,0,0,2);
    v(1,4,32'hc,   0,0,0,        0,0,  1,4,32'hc,         0,1,0,1);
    v(0,0,0,       0,0,0,        0,0,  1,2,32'h22,        0,1,0,1);
    v(0,0,0,       0,0,0,        0,0,  0,0,0,             0,1,0,0);

    #2;
    chk("reset_outputs", {rf_we, ws_stall, lu_ready, ds_pend_hit, fifo_count}, 6'b0);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].ws_we, vq[i].ws_wa, vq[i].ws_wd, vq[i].lv, vq[i].ld, vq[i].lwd);
      ds_raddr1 = vq[i].r1;
      ds_raddr2 = vq[i].r2;
      #4;
      chk($sformatf("vec%0d", i),
          {rf_we, rf_waddr, rf_wdata, ws_stall, lu_ready, ds_pend_hit, fifo_count}, vq[i].exp);
    end

    // asynchronous reset with two entries buffered
    @(negedge clk) drive(1, 3, 32'hb, 1, 10, 32'h100);
    @(negedge clk) drive(1, 3, 32'hb, 1, 11, 32'h111);
    @(negedge clk) drive(1, 3, 32'hb, 0, 0, 0);
    ds_raddr1 = 5'd10;
    #1 chk("pre_reset_count", fifo_count, 2);
    #1 resetn = 1'b0;
    #1 chk("mid_reset", {rf_we, ws_stall, lu_ready, ds_pend_hit, fifo_count}, 6'b0);
    @(negedge clk);
    #2 resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("post_reset", {lu_ready, ds_pend_hit, fifo_count}, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #4 chk($sformatf("no_stale%0d", i), {rf_we, fifo_count}, 3'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage (WS) and a long-latency unit (LU, e.g. divider/multiplier) that returns results out of band.
- WS normally has priority. LU results wait in a small in-order FIFO and use the port on cycles when WS does not write, or take it by stalling WS once a starvation limit is reached.
- Also tells decode when a source register still has a write pending in the FIFO.

Parameters:
- FIFO_DEPTH, 2, number of LU result entries buffered (≥1).
- STARVE_LIMIT, 4, consecutive ungranted cycles before the LU head forces a WS stall (≥1).
- CW, $clog2(FIFO_DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- ws_to_rf_bus  input  38  WS write request: {we[37], waddr[36:32], wdata[31:0]}; we is already gated with ws_valid.
- ws_stall  output  1  when 1, WS must hold its instruction this cycle (drive ws_ready_go=0) and re-present the same bus next cycle.
- lu_valid  input  1  LU result valid.
- lu_ready  output  1  arbiter can accept an LU result.
- lu_dest  input  5  LU destination register.
- lu_wdata  input  32  LU result data.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- ds_raddr1  input  5  decode source register 1.
- ds_raddr2  input  5  decode source register 2.
- ds_pend_hit  output  1  a FIFO entry targets a nonzero decode source register.
- fifo_count  output  CW  current FIFO occupancy.

Behaviour:
- Reset (resetn low, asynchronous): FIFO emptied (rd/wr pointers and count = 0), starve counter = 0.
  - While in reset, outputs are forced: rf_we=0, ws_stall=0, lu_ready=0, ds_pend_hit=0, fifo_count=0.
- FIFO:
  - lu_ready = (count < FIFO_DEPTH). Decided from the registered count only; no enqueue on a full FIFO even if a dequeue happens the same cycle.
  - Handshake: lu_valid && lu_ready.
    - lu_dest != 0: entry {lu_dest, lu_wdata} is written at the tail on the next rising edge.
    - lu_dest == 0: result is accepted and dropped; count is unchanged.
  - An entry is visible to arbitration from the cycle after it is written; there is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH. Retirement is strictly FIFO order.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- starve = (starve_cnt >= STARVE_LIMIT).
- Grant, combinational each cycle:
  - FIFO empty: rf_* = ws_to_rf_bus fields, ws_stall=0.
  - FIFO nonempty and ws we=0: grant LU. rf_we=1, rf_waddr/rf_wdata = head entry, dequeue at edge, ws_stall=0.
  - FIFO nonempty, ws we=1, !starve: grant WS. rf_* = WS fields, ws_stall=0.
  - FIFO nonempty, ws we=1, starve: grant LU. ws_stall=1, head written and dequeued, WS write suppressed this cycle.
- Starve counter, updated at edge:
  - Reset to 0 when the FIFO is empty or the LU is granted.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Port latency: WS writes are combinational pass-through, zero added cycles. A buffered LU result writes at least 1 cycle after acceptance.
- ds_pend_hit = OR over valid entries of (dest == ds_raddr1 && ds_raddr1 != 0) || (dest == ds_raddr2 && ds_raddr2 != 0).
  - Only registered FIFO contents are compared, not the in-flight lu_dest.
- WAW ordering between WS and LU to the same register is not checked here. Issue logic guarantees it.
- fifo_count = registered count.

Test Plan:
- Reset mid-operation: FIFO holding 2 entries, drop resetn asynchronously between edges -> rf_we=0, fifo_count=0, lu_ready=0 immediately. After release, lu_ready=1 and no stale entry is ever written.
- Idle WS: ws we=0; LU pushes {dest=5, data=0x1234} at cycle 0 -> cycle 1 rf_we=1, rf_waddr=5, rf_wdata=0x1234; cycle 2 fifo_count=0.
- WS priority: FIFO holds {dest=7, data=0xA}; WS writes {3, 0xB} every cycle -> cycles 1-4 rf_waddr=3, ws_stall=0. Cycle 5 (starve, STARVE_LIMIT=4) ws_stall=1, rf_waddr=7, rf_wdata=0xA. Cycle 6 WS's held {3, 0xB} is written.
- Full FIFO: push {1, 0x11} and {2, 0x22} while WS writes continuously -> fifo_count=2, lu_ready=0; a third lu_valid is not accepted. After the first starve grant (0x11), lu_ready=1 and order is preserved (0x11 then 0x22).
- r0 drop: lu_valid with lu_dest=0 -> accepted (lu_ready=1), fifo_count stays 0, no rf_we from LU.
- Pending hit: FIFO holds dest=9.
  - ds_raddr1=9 -> ds_pend_hit=1.
  - ds_raddr1=0, ds_raddr2=8 -> ds_pend_hit=0.
  - After entry 9 retires -> ds_pend_hit=0 with ds_raddr1=9.
